// File: rtl/udma_smi_arbiter_if.sv
// Bundle of the requester-side and SMI-engine-side signals of the SMI arbiter.
// The arbiter connects through the slave modport; requesters and engine use master.
interface udma_smi_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ-1:0]    req_rw_i;
  logic [5*NUM_REQ-1:0]  req_phy_addr_i;
  logic [5*NUM_REQ-1:0]  req_reg_addr_i;
  logic [16*NUM_REQ-1:0] req_wr_data_i;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [15:0]           rsp_data_o;
  logic                  rsp_err_o;
  logic                  smi_start_o;
  logic                  smi_rw_o;
  logic [4:0]            smi_phy_addr_o;
  logic [4:0]            smi_reg_addr_o;
  logic [15:0]           smi_wr_data_o;
  logic                  smi_busy_i;
  logic                  smi_nd_i;
  logic [15:0]           smi_rd_data_i;

  modport slave (
    input  req_valid_i, req_rw_i, req_phy_addr_i, req_reg_addr_i, req_wr_data_i,
    input  smi_busy_i, smi_nd_i, smi_rd_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output smi_start_o, smi_rw_o, smi_phy_addr_o, smi_reg_addr_o, smi_wr_data_o
  );

  modport master (
    output req_valid_i, req_rw_i, req_phy_addr_i, req_reg_addr_i, req_wr_data_i,
    output smi_busy_i, smi_nd_i, smi_rd_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  smi_start_o, smi_rw_o, smi_phy_addr_o, smi_reg_addr_o, smi_wr_data_o
  );
endinterface

// File: rtl/udma_smi_arbiter.sv
// Round-robin arbiter sharing one SMI (MDIO) engine between NUM_REQ requesters,
// with a per-wait-state timeout that completes the transaction with an error.
module udma_smi_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024
) (
  input logic              clk_i,
  input logic              rstn_i,
  udma_smi_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr, win_idx, cur_idx;
  logic           win_found;
  logic           sel_rw, cur_rw;
  logic [4:0]     sel_phy, sel_reg, cur_phy, cur_reg;
  logic [15:0]    sel_wdata, cur_wdata;
  logic [CW-1:0]  cnt;
  logic           expired;
  logic [15:0]    rsp_data;
  logic           rsp_err;
  logic [NUM_REQ-1:0] ready, rsp_valid;
  logic           start;

  // The engine's new-data strobe carries no information the busy edge lacks.
  logic unused_nd;
  assign unused_nd = bus.smi_nd_i;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return IW'(s);
  endfunction

  // Winner: first valid requester at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req_valid_i[wrap_idx(ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(ptr, i);
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_phy   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) begin
        sel_rw    = bus.req_rw_i[k];
        sel_phy   = bus.req_phy_addr_i[5*k +: 5];
        sel_reg   = bus.req_reg_addr_i[5*k +: 5];
        sel_wdata = bus.req_wr_data_i[16*k +: 16];
      end
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (win_found) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (bus.smi_busy_i) state_nxt = WAIT_DONE;
                 else if (expired)   state_nxt = RESP;
      WAIT_DONE: if (!bus.smi_busy_i || expired) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = '0;
    rsp_valid = '0;
    start     = 1'b0;
    case (state)
      IDLE:    if (win_found) ready[win_idx] = 1'b1;
      ISSUE:   start = 1'b1;
      RESP:    rsp_valid[cur_idx] = 1'b1;
      default: ;
    endcase
  end

  // Command latch, wait-state counter, response registers and round-robin pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_idx   <= '0;
      cur_rw    <= 1'b0;
      cur_phy   <= '0;
      cur_reg   <= '0;
      cur_wdata <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          cur_idx   <= win_idx;
          cur_rw    <= sel_rw;
          cur_phy   <= sel_phy;
          cur_reg   <= sel_reg;
          cur_wdata <= sel_wdata;
        end
        ISSUE: cnt <= '0;
        WAIT_BUSY: begin
          if (bus.smi_busy_i) cnt <= '0;
          else if (expired) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_DONE: begin
          // Completion is checked before expiry so a same-cycle finish is not an error.
          if (!bus.smi_busy_i) begin
            rsp_err  <= 1'b0;
            rsp_data <= cur_rw ? 16'h0 : bus.smi_rd_data_i;
          end else if (expired) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else cnt <= cnt + 1'b1;
        end
        RESP: ptr <= (cur_idx == IW'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o    = ready;
  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.rsp_data_o     = rsp_data;
  assign bus.rsp_err_o      = rsp_err;
  assign bus.smi_start_o    = start;
  assign bus.smi_rw_o       = cur_rw;
  assign bus.smi_phy_addr_o = cur_phy;
  assign bus.smi_reg_addr_o = cur_reg;
  assign bus.smi_wr_data_o  = cur_wdata;

endmodule

// File: tb/tb_udma_smi_arbiter.sv
// Bench for udma_smi_arbiter: arbitration table under reset, directed corner
// sequences on two instances (long and short timeout), and randomized traffic.
module tb_udma_smi_arbiter;

  localparam int N  = 3;
  localparam int AW = 5 * N;
  localparam int DW = 16 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [N-1:0]  req_valid, req_rw;
  logic [AW-1:0] req_phy, req_reg;
  logic [DW-1:0] req_wdata;
  logic          smi_busy, smi_nd;
  logic [15:0]   smi_rd_data;

  udma_smi_arbiter_if #(.NUM_REQ(N)) if_m ();
  udma_smi_arbiter_if #(.NUM_REQ(N)) if_t ();

  assign if_m.req_valid_i = req_valid;   assign if_t.req_valid_i = req_valid;
  assign if_m.req_rw_i = req_rw;         assign if_t.req_rw_i = req_rw;
  assign if_m.req_phy_addr_i = req_phy;  assign if_t.req_phy_addr_i = req_phy;
  assign if_m.req_reg_addr_i = req_reg;  assign if_t.req_reg_addr_i = req_reg;
  assign if_m.req_wr_data_i = req_wdata; assign if_t.req_wr_data_i = req_wdata;
  assign if_m.smi_busy_i = smi_busy;     assign if_t.smi_busy_i = smi_busy;
  assign if_m.smi_nd_i = smi_nd;         assign if_t.smi_nd_i = smi_nd;
  assign if_m.smi_rd_data_i = smi_rd_data; assign if_t.smi_rd_data_i = smi_rd_data;

  udma_smi_arbiter #(.NUM_REQ(N), .TIMEOUT(1024)) dut    (.clk_i(clk), .rstn_i(rstn), .bus(if_m));
  udma_smi_arbiter #(.NUM_REQ(N), .TIMEOUT(16))   dut_to (.clk_i(clk), .rstn_i(rstn), .bus(if_t));

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
  } arb_vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SMI engine: after a start it idles eng_delay cycles, stays
  // busy eng_len cycles, then drops busy and presents read data.
  bit          eng_on = 1'b0, eng_rand = 1'b0, eng_sel = 1'b0;
  int          eng_delay = 1, eng_len = 1, eng_d, eng_l;
  logic [15:0] eng_data = '0, eng_dat, eng_last_data = '0;

  initial begin
    smi_busy    = 1'b0;
    smi_rd_data = '0;
    forever begin
      @(negedge clk); #1;
      if (eng_on && (eng_sel ? if_t.smi_start_o : if_m.smi_start_o)) begin
        eng_d   = eng_rand ? int'($urandom_range(1, 3)) : eng_delay;
        eng_l   = eng_rand ? int'($urandom_range(1, 6)) : eng_len;
        eng_dat = eng_rand ? 16'($urandom) : eng_data;
        repeat (eng_d) @(negedge clk);
        smi_busy = 1'b1;
        repeat (eng_l) @(negedge clk);
        smi_busy      = 1'b0;
        smi_rd_data   = eng_dat;
        eng_last_data = eng_dat;
      end
    end
  end

  int starts_m = 0, rsps_m = 0;
  initial forever begin
    @(negedge clk); #2;
    if (if_m.smi_start_o) starts_m++;
    if (|if_m.rsp_valid_o) rsps_m++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input bit sel, input int idx, input bit rw, input logic [4:0] phy,
                      input logic [4:0] rg, input logic [15:0] wd);
    logic [N-1:0] rdy;
    bit ok;
    @(negedge clk);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_rw[idx] = rw;
    req_phy[5*idx +: 5] = phy;
    req_reg[5*idx +: 5] = rg;
    req_wdata[16*idx +: 16] = wd;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      rdy = sel ? if_t.req_ready_o : if_m.req_ready_o;
      if (rdy[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", 32'(ok), 32'd1);
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input bit sel, input int max, output int cyc);
    logic [N-1:0] v;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
      v = sel ? if_t.rsp_valid_o : if_m.rsp_valid_o;
    end while (v == '0 && cyc < max);
    check("rsp_seen", 32'(|v), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  arb_vec_t     arb_tbl [7];
  int           cyc, s0, r0, n_got, last;
  logic [N-1:0] rdy, exp_rdy, exp_v;
  int           mptr, cur, acc_cyc;
  bit           outst, start_due, cur_rw;
  logic [4:0]   cphy, creg;
  logic [15:0]  cwd, mdata;

  initial begin
    arb_tbl[0] = '{3'b000, 3'b000};
    arb_tbl[1] = '{3'b001, 3'b001};
    arb_tbl[2] = '{3'b010, 3'b010};
    arb_tbl[3] = '{3'b110, 3'b010};
    arb_tbl[4] = '{3'b101, 3'b001};
    arb_tbl[5] = '{3'b111, 3'b001};
    arb_tbl[6] = '{3'b100, 3'b100};

    rstn = 1'b0; req_valid = '0; req_rw = '0; req_phy = '0; req_reg = '0;
    req_wdata = '0; smi_nd = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_start", 32'(if_m.smi_start_o), 32'd0);
    check("rst_rsp_valid", 32'(if_m.rsp_valid_o), 32'd0);
    check("rst_rsp_data", 32'(if_m.rsp_data_o), 32'd0);
    check("rst_rsp_err", 32'(if_m.rsp_err_o), 32'd0);
    check("rst_smi_fields", {if_m.smi_rw_o, if_m.smi_phy_addr_o, if_m.smi_reg_addr_o, if_m.smi_wr_data_o}, 32'd0);

    // Arbitration from pointer 0 while held in reset
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = arb_tbl[i].valid;
      #1;
      check("arb_reset", 32'(if_m.req_ready_o), 32'(arb_tbl[i].ready));
    end
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;

    // Single read on requester 1
    eng_on = 1'b1; eng_sel = 1'b0; eng_delay = 1; eng_len = 20; eng_data = 16'h796D;
    s0 = starts_m; r0 = rsps_m;
    send(1'b0, 1, 1'b0, 5'h03, 5'h01, 16'h0000);
    #1;
    check("rd_start", 32'(if_m.smi_start_o), 32'd1);
    check("rd_cmd", {if_m.smi_rw_o, if_m.smi_phy_addr_o, if_m.smi_reg_addr_o}, {21'd0, 1'b0, 5'h03, 5'h01});
    wait_rsp(1'b0, 60, cyc);
    check("rd_latency", 32'(cyc), 32'd22);
    check("rd_rsp_valid", 32'(if_m.rsp_valid_o), 32'b010);
    check("rd_rsp_data", 32'(if_m.rsp_data_o), 32'h796D);
    check("rd_rsp_err", 32'(if_m.rsp_err_o), 32'd0);
    @(negedge clk); #1;
    check("rd_rsp_pulse", 32'(if_m.rsp_valid_o), 32'd0);
    check("rd_start_count", 32'(starts_m - s0), 32'd1);
    check("rd_rsp_count", 32'(rsps_m - r0), 32'd1);

    // Write on requester 2
    eng_len = 3; eng_data = 16'h1234;
    send(1'b0, 2, 1'b1, 5'h11, 5'h0A, 16'hA5A5);
    #1;
    check("wr_start", 32'(if_m.smi_start_o), 32'd1);
    check("wr_rw", 32'(if_m.smi_rw_o), 32'd1);
    check("wr_data_out", 32'(if_m.smi_wr_data_o), 32'hA5A5);
    wait_rsp(1'b0, 30, cyc);
    check("wr_rsp_valid", 32'(if_m.rsp_valid_o), 32'b100);
    check("wr_rsp_data", 32'(if_m.rsp_data_o), 32'h0000);
    check("wr_rsp_err", 32'(if_m.rsp_err_o), 32'd0);

    // Busy falls on the very cycle the short-timeout counter expires
    do_reset();
    eng_sel = 1'b1; eng_delay = 1; eng_len = 16; eng_data = 16'hC3E1;
    send(1'b1, 1, 1'b0, 5'h04, 5'h02, 16'h0000);
    #1;
    check("tie_start", 32'(if_t.smi_start_o), 32'd1);
    wait_rsp(1'b1, 40, cyc);
    check("tie_latency", 32'(cyc), 32'd18);
    check("tie_rsp_valid", 32'(if_t.rsp_valid_o), 32'b010);
    check("tie_rsp_err", 32'(if_t.rsp_err_o), 32'd0);
    check("tie_rsp_data", 32'(if_t.rsp_data_o), 32'hC3E1);

    // Busy never rises: timeout response 16 cycles after WAIT_BUSY entry
    eng_on = 1'b0;
    send(1'b1, 1, 1'b0, 5'h04, 5'h02, 16'h0000);
    #1;
    check("to_start", 32'(if_t.smi_start_o), 32'd1);
    wait_rsp(1'b1, 40, cyc);
    check("to_latency", 32'(cyc), 32'd17);
    check("to_rsp_valid", 32'(if_t.rsp_valid_o), 32'b010);
    check("to_rsp_err", 32'(if_t.rsp_err_o), 32'd1);
    check("to_rsp_data", 32'(if_t.rsp_data_o), 32'h0000);
    repeat (3) @(negedge clk);
    #1;
    check("to_err_hold", 32'(if_t.rsp_err_o), 32'd1);
    check("to_no_pulse", 32'(if_t.rsp_valid_o), 32'd0);

    // Fairness: all requesters valid continuously
    do_reset();
    eng_on = 1'b1; eng_sel = 1'b0; eng_delay = 1; eng_len = 2; eng_data = 16'h5A3C;
    req_rw = '0;
    req_phy = {5'd3, 5'd2, 5'd1};
    @(negedge clk);
    req_valid = '1;
    n_got = 0; last = -100;
    for (int c = 0; c < 200 && n_got < 6; c++) begin
      #1;
      rdy = if_m.req_ready_o;
      if (rdy != '0) begin
        exp_v = '0;
        exp_v[n_got % N] = 1'b1;
        check("fair_grant", 32'(rdy), 32'(exp_v));
        if (n_got > 0) check("fair_spacing", 32'((c - last) >= 5), 32'd1);
        last = c;
        n_got++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("fair_count", 32'(n_got), 32'd6);
    wait_rsp(1'b0, 40, cyc);
    check("fair_last_data", 32'(if_m.rsp_data_o), 32'h5A3C);

    // Reset asserted in WAIT_DONE
    eng_len = 10;
    send(1'b0, 0, 1'b1, 5'h07, 5'h1F, 16'hBEEF);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_start", 32'(if_m.smi_start_o), 32'd0);
    check("mid_rsp_valid", 32'(if_m.rsp_valid_o), 32'd0);
    check("mid_rsp_data", 32'(if_m.rsp_data_o), 32'd0);
    check("mid_rsp_err", 32'(if_m.rsp_err_o), 32'd0);
    check("mid_smi_fields", {if_m.smi_rw_o, if_m.smi_phy_addr_o, if_m.smi_reg_addr_o, if_m.smi_wr_data_o}, 32'd0);
    check("mid_ready", 32'(if_m.req_ready_o), 32'd0);
    s0 = starts_m; r0 = rsps_m;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (25) @(negedge clk);
    check("mid_no_start", 32'(starts_m - s0), 32'd0);
    check("mid_no_rsp", 32'(rsps_m - r0), 32'd0);

    // Randomized traffic against a transaction-level model
    eng_rand = 1'b1; eng_sel = 1'b0; eng_on = 1'b1;
    mptr = 0; outst = 1'b0; start_due = 1'b0; acc_cyc = -100; mdata = '0;
    cur = 0; cur_rw = 1'b0; cphy = '0; creg = '0; cwd = '0;
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 7));
      req_rw    = N'($urandom);
      req_phy   = AW'($urandom);
      req_reg   = AW'($urandom);
      req_wdata = DW'({$urandom, $urandom});
      smi_nd    = 1'($urandom);
      #1;
      exp_rdy = '0;
      if (!outst)
        for (int i = 0; i < N; i++)
          if (exp_rdy == '0 && req_valid[(mptr + i) % N]) exp_rdy[(mptr + i) % N] = 1'b1;
      check("rnd_ready", 32'(if_m.req_ready_o), 32'(exp_rdy));
      if (if_m.rsp_valid_o != '0) begin
        exp_v = '0;
        if (outst) exp_v[cur] = 1'b1;
        check("rnd_rsp_owner", 32'(if_m.rsp_valid_o), 32'(exp_v));
        if (outst) begin
          mdata = cur_rw ? 16'h0 : eng_last_data;
          outst = 1'b0;
          mptr  = (cur + 1) % N;
        end
      end else if (outst && (c - acc_cyc) > 40) begin
        check("rnd_rsp_late", 32'(c - acc_cyc), 32'd40);
        outst = 1'b0;
      end
      check("rnd_rsp_data", 32'(if_m.rsp_data_o), 32'(mdata));
      check("rnd_rsp_err", 32'(if_m.rsp_err_o), 32'd0);
      check("rnd_start", 32'(if_m.smi_start_o), 32'(start_due));
      if (start_due)
        check("rnd_cmd", {if_m.smi_rw_o, if_m.smi_phy_addr_o, if_m.smi_reg_addr_o, if_m.smi_wr_data_o},
              {5'd0, cur_rw, cphy, creg, cwd});
      start_due = 1'b0;
      if (exp_rdy != '0) begin
        for (int i = 0; i < N; i++) if (exp_rdy[i]) cur = i;
        cur_rw = req_rw[cur];
        cphy   = req_phy[5*cur +: 5];
        creg   = req_reg[5*cur +: 5];
        cwd    = req_wdata[16*cur +: 16];
        outst     = 1'b1;
        start_due = 1'b1;
        acc_cyc   = c;
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
